multi_port_ram: RTL and testbench

MULTI_PORT_RAM -- requirements
Module: multi_port_ram

---
 rtl/multi_port_ram_pkg.sv | 21 ++
 rtl/multi_port_ram_rr_arbiter.sv | 37 +++
 rtl/multi_port_ram.sv | 149 ++++++++++++++
 tb/tb_multi_port_ram.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_ram_pkg.sv
// Shared definitions for the multi-port SRAM controller: FSM encoding,
// arbitration mode constants and SRAM bus geometry.
package multi_port_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam int ARB_FIXED  = 0;
  localparam int ARB_RR     = 1;
  localparam int RAM_ADDR_W = 30;
  localparam int RAM_DATA_W = 32;

  // Width of a port index; a single-port build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_port_ram_rr_arbiter.sv
// Combinational arbiter: fixed priority (port 0 first) or round-robin
// starting one past the previous winner.
module rr_arbiter
  import multi_port_ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 rr_mode,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_vld
);

  always_comb begin
    int base;
    int p;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    base      = rr_mode ? int'(last_grant) + 1 : 0;
    p         = 0;
    // base + k stays below 2*NUM_PORTS, so one wrap is enough
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = base + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!grant_vld && req[p]) begin
        grant[p]  = 1'b1;
        grant_idx = IDX_W'(p);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_ram.sv
// Multi-master asynchronous SRAM controller: one access at a time, strobes
// held for ACCESS_CYCLES, then a one-cycle ack to the granted port.
module multi_port_ram
  import multi_port_ram_pkg::*;
#(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_W        = 22,
  parameter int ARB_MODE      = 0,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_address,
  input  logic [NUM_PORTS*32-1:0]     port_wrdata,
  input  logic [NUM_PORTS*4-1:0]      port_dataenable,
  input  logic [NUM_PORTS-1:0]        port_rd,
  input  logic [NUM_PORTS-1:0]        port_wr,
  output logic [NUM_PORTS*32-1:0]     port_rddata,
  output logic [NUM_PORTS-1:0]        port_ack,
  output logic [RAM_ADDR_W-1:0]       ram_address,
  inout  wire  [RAM_DATA_W-1:0]       ram_data,
  output logic                        ram_rd_n,
  output logic                        ram_wr_n,
  output logic [3:0]                  ram_dataenable
);

  localparam int             IDX_W     = idx_width(NUM_PORTS);
  localparam logic [3:0]     LAST_CNT  = 4'(ACCESS_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_PORTS - 1);
  localparam logic           RR_EN     = (ARB_MODE == ARB_RR);

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    acc_last;
  logic                    take;
  logic                    drive_en;
  logic [NUM_PORTS-1:0]    req, gnt_oh, gnt_oh_p0;
  logic [IDX_W-1:0]        gnt_idx, gnt_idx_p0, last_grant;
  logic                    gnt_vld;
  logic                    wr_p0;
  logic [RAM_ADDR_W-1:0]   addr_p0;
  logic [RAM_DATA_W-1:0]   wdata_p0;
  logic [3:0]              be_p0;
  logic [ADDR_W-1:0]       addr_a  [NUM_PORTS];
  logic [31:0]             wdata_a [NUM_PORTS];
  logic [3:0]              be_a    [NUM_PORTS];
  logic [31:0]             rdata_q [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign addr_a[g]                = port_address[g*ADDR_W +: ADDR_W];
    assign wdata_a[g]               = port_wrdata[g*32 +: 32];
    assign be_a[g]                  = port_dataenable[g*4 +: 4];
    assign port_rddata[g*32 +: 32]  = rdata_q[g];
  end

  assign req = port_rd | port_wr;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .req        (req),
    .rr_mode    (RR_EN),
    .last_grant (last_grant),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx),
    .grant_vld  (gnt_vld)
  );

  assign take     = (state == ST_IDLE) && gnt_vld;
  assign acc_last = (state == ST_ACCESS) && (cnt == LAST_CNT);

  // Stage p0: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (gnt_vld)  state_nxt = ST_ACCESS;
      ST_ACCESS: if (acc_last) state_nxt = ST_ACK;
      ST_ACK:                  state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // Strobes, lanes and bus drive decode straight from the state so that a
  // reset releases the SRAM in the same instant it is asserted.
  always_comb begin
    ram_rd_n       = 1'b1;
    ram_wr_n       = 1'b1;
    ram_dataenable = 4'hF;
    drive_en       = 1'b0;
    port_ack       = '0;
    case (state)
      ST_ACCESS: begin
        ram_rd_n       = wr_p0;
        ram_wr_n       = !wr_p0;
        ram_dataenable = ~be_p0;
        drive_en       = wr_p0;
      end
      ST_ACK:  port_ack = gnt_oh_p0;
      default: ;
    endcase
  end

  // Stage p0: latched grant and operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      gnt_oh_p0  <= '0;
      gnt_idx_p0 <= '0;
      wr_p0      <= 1'b0;
      addr_p0    <= '0;
      last_grant <= LAST_INIT;
    end else if (take) begin
      cnt        <= '0;
      gnt_oh_p0  <= gnt_oh;
      gnt_idx_p0 <= gnt_idx;
      wr_p0      <= port_wr[gnt_idx];
      addr_p0    <= RAM_ADDR_W'(addr_a[gnt_idx]);
      last_grant <= gnt_idx;
    end else if (state == ST_ACCESS) begin
      cnt        <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      wdata_p0 <= wdata_a[gnt_idx];
      be_p0    <= be_a[gnt_idx];
    end
  end

  // Stage p1: read data capture on the final strobe cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) rdata_q[i] <= '0;
    end else if (acc_last && !wr_p0) begin
      rdata_q[gnt_idx_p0] <= ram_data;
    end
  end

  assign ram_address = addr_p0;
  assign ram_data    = drive_en ? wdata_p0 : 'z;

endmodule

// File: tb/tb_multi_port_ram.sv
// Bench for multi_port_ram: a fixed-priority single-cycle instance and a
// round-robin four-cycle instance, each with a behavioural SRAM on its bus.
module tb_multi_port_ram;

  localparam int NP  = 3;
  localparam int AW  = 22;
  localparam int AC0 = 1;
  localparam int AC1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NP*AW-1:0] p_addr  [2];
  logic [NP*32-1:0] p_wdata [2];
  logic [NP*4-1:0]  p_be    [2];
  logic [NP-1:0]    p_rd    [2];
  logic [NP-1:0]    p_wr    [2];

  wire [NP*32-1:0] rdata0, rdata1;
  wire [NP-1:0]    ack0, ack1;
  wire [29:0]      raddr0, raddr1;
  wire             rrd0, rrd1, rwr0, rwr1;
  wire [3:0]       rbe0, rbe1;
  wire [31:0]      bus0, bus1;

  multi_port_ram #(.NUM_PORTS(NP), .ADDR_W(AW), .ARB_MODE(0), .ACCESS_CYCLES(AC0)) u0 (
    .clk(clk), .rst_n(rst_n), .port_address(p_addr[0]), .port_wrdata(p_wdata[0]),
    .port_dataenable(p_be[0]), .port_rd(p_rd[0]), .port_wr(p_wr[0]),
    .port_rddata(rdata0), .port_ack(ack0), .ram_address(raddr0), .ram_data(bus0),
    .ram_rd_n(rrd0), .ram_wr_n(rwr0), .ram_dataenable(rbe0));

  multi_port_ram #(.NUM_PORTS(NP), .ADDR_W(AW), .ARB_MODE(1), .ACCESS_CYCLES(AC1)) u1 (
    .clk(clk), .rst_n(rst_n), .port_address(p_addr[1]), .port_wrdata(p_wdata[1]),
    .port_dataenable(p_be[1]), .port_rd(p_rd[1]), .port_wr(p_wr[1]),
    .port_rddata(rdata1), .port_ack(ack1), .ram_address(raddr1), .ram_data(bus1),
    .ram_rd_n(rrd1), .ram_wr_n(rwr1), .ram_dataenable(rbe1));

  // Behavioural SRAMs: drive on read strobe, merge enabled lanes while writing
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  assign bus0 = !rrd0 ? mem0[raddr0[9:0]] : 'z;
  assign bus1 = !rrd1 ? mem1[raddr1[9:0]] : 'z;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!rwr0 && !rbe0[b]) mem0[raddr0[9:0]][b*8 +: 8] <= bus0[b*8 +: 8];
      if (!rwr1 && !rbe1[b]) mem1[raddr1[9:0]][b*8 +: 8] <= bus1[b*8 +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [2][1024];
  logic [31:0] e_rd    [2][NP];
  int          lastg   [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    int          d;
    int          p;
    bit          rd;
    bit          wr;
    logic [21:0] a;
    logic [31:0] w;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP-1:0] ack_of(input int d);
    return (d == 0) ? ack0 : ack1;
  endfunction
  function automatic logic [NP*32-1:0] rdata_of(input int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction
  function automatic logic [1:0] strobes_of(input int d);
    return (d == 0) ? {rrd0, rwr0} : {rrd1, rwr1};
  endfunction
  function automatic logic [29:0] raddr_of(input int d);
    return (d == 0) ? raddr0 : raddr1;
  endfunction
  function automatic logic [3:0] rbe_of(input int d);
    return (d == 0) ? rbe0 : rbe1;
  endfunction
  function automatic logic [31:0] bus_of(input int d);
    return (d == 0) ? bus0 : bus1;
  endfunction
  function automatic bit bus_idle(input int d);
    logic [31:0] b;
    b = bus_of(d);
    return (b === 32'h0) || (b === 32'hzzzzzzzz);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  task automatic set_req(input int d, input int p, input bit rd, input bit wr,
                         input logic [21:0] a, input logic [31:0] w, input logic [3:0] be);
    p_addr[d][p*AW +: AW] = a;
    p_wdata[d][p*32 +: 32] = w;
    p_be[d][p*4 +: 4] = be;
    p_rd[d][p] = rd;
    p_wr[d][p] = wr;
  endtask

  task automatic clear_req(input int d);
    p_addr[d] = '0; p_wdata[d] = '0; p_be[d] = '0; p_rd[d] = '0; p_wr[d] = '0;
  endtask

  task automatic check_rd(input int d, input string tag);
    logic [NP*32-1:0] rv;
    rv = rdata_of(d);
    for (int p = 0; p < NP; p++)
      check($sformatf("%s rddata[%0d]", tag, p), 64'(rv[p*32 +: 32]), 64'(e_rd[d][p]));
  endtask

  task automatic xfer(input int d, input int p, input bit rd, input bit wr, input logic [21:0] a,
                      input logic [31:0] w, input logic [3:0] be, input string tag);
    int ac, lat, low_rd, low_wr;
    bit ok;
    logic [NP-1:0] ak;
    logic [1:0] st;
    ac = (d == 0) ? AC0 : AC1;
    lat = 0; low_rd = 0; low_wr = 0; ok = 1'b1; ak = '0;
    set_req(d, p, rd, wr, a, w, be);
    while (ak == '0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      ak = ack_of(d);
      if (ak == '0) begin
        st = strobes_of(d);
        if (!st[1]) low_rd++;
        if (!st[0]) low_wr++;
        if (raddr_of(d) !== {8'd0, a} || rbe_of(d) !== ~be) ok = 1'b0;
        if (wr && bus_of(d) !== w) ok = 1'b0;
      end
    end
    clear_req(d);
    check({tag, " ack"}, 64'(ak), 64'(1 << p));
    check({tag, " latency"}, 64'(lat), 64'(ac + 1));
    check({tag, " rd_n low cycles"}, 64'(low_rd), 64'(wr ? 0 : ac));
    check({tag, " wr_n low cycles"}, 64'(low_wr), 64'(wr ? ac : 0));
    check({tag, " addr/lanes/bus in access"}, 64'(ok), 64'(1));
    check({tag, " strobes in ack"}, 64'(strobes_of(d)), 64'(2'b11));
    if (wr) ref_mem[d][a[9:0]] = merge(ref_mem[d][a[9:0]], w, be);
    else    e_rd[d][p] = ref_mem[d][a[9:0]];
    lastg[d] = p;
    @(posedge clk); #1;
    check({tag, " bus released"}, 64'(bus_idle(d)), 64'(1));
    check_rd(d, tag);
  endtask

  // All ports hold read requests; model predicts the winner sequence and spacing
  task automatic contend(input int d, input int mode, input int n, input string tag);
    int ac, exp_p, t, prev_t, lat;
    logic [NP-1:0] ak;
    ac = (d == 0) ? AC0 : AC1;
    for (int p = 0; p < NP; p++) set_req(d, p, 1'b1, 1'b0, 22'h300 + 22'(p), 32'h0, 4'hF);
    t = 0; prev_t = 0;
    for (int k = 0; k < n; k++) begin
      exp_p = mode ? (lastg[d] + 1) % NP : 0;
      ak = '0; lat = 0;
      while (ak == '0 && lat < 40) begin
        @(posedge clk); #1;
        t++; lat++;
        ak = ack_of(d);
      end
      check($sformatf("%s grant #%0d", tag, k), 64'(ak), 64'(1 << exp_p));
      if (k > 0) check($sformatf("%s spacing #%0d", tag, k), 64'(t - prev_t), 64'(ac + 2));
      prev_t = t;
      lastg[d] = exp_p;
      e_rd[d][exp_p] = ref_mem[d][10'h300 + 10'(exp_p)];
      if (k == n - 1) clear_req(d);
      check_rd(d, $sformatf("%s #%0d", tag, k));
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int d, input int mode, input int n);
    int ac, win, q, lat;
    int op [NP];
    logic [21:0] ra [NP];
    logic [31:0] rw [NP];
    logic [3:0]  rb [NP];
    logic [NP-1:0] rq, ak;
    ac = (d == 0) ? AC0 : AC1;
    for (int it = 0; it < n; it++) begin
      rq = NP'($urandom_range(1, (1 << NP) - 1));
      for (int p = 0; p < NP; p++) begin
        op[p] = $urandom_range(0, 2);
        ra[p] = 22'h200 + 22'($urandom_range(0, 7));
        rw[p] = $urandom;
        rb[p] = 4'($urandom_range(0, 15));
        if (rq[p]) set_req(d, p, op[p] != 1, op[p] != 0, ra[p], rw[p], rb[p]);
      end
      win = -1;
      for (int k = 1; k <= NP; k++) begin
        q = mode ? (lastg[d] + k) % NP : k - 1;
        if (win < 0 && rq[q]) win = q;
      end
      ak = '0; lat = 0;
      while (ak == '0 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
        ak = ack_of(d);
      end
      clear_req(d);
      check($sformatf("rand%0d.%0d winner", d, it), 64'(ak), 64'(1 << win));
      check($sformatf("rand%0d.%0d latency", d, it), 64'(lat), 64'(ac + 1));
      if (op[win] != 0) ref_mem[d][ra[win][9:0]] = merge(ref_mem[d][ra[win][9:0]], rw[win], rb[win]);
      else              e_rd[d][win] = ref_mem[d][ra[win][9:0]];
      lastg[d] = win;
      @(posedge clk); #1;
      check_rd(d, $sformatf("rand%0d.%0d", d, it));
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s u%0d strobes", tag, d), 64'(strobes_of(d)), 64'(2'b11));
      check($sformatf("%s u%0d lanes", tag, d), 64'(rbe_of(d)), 64'(4'hF));
      check($sformatf("%s u%0d address", tag, d), 64'(raddr_of(d)), 64'(0));
      check($sformatf("%s u%0d ack", tag, d), 64'(ack_of(d)), 64'(0));
      check($sformatf("%s u%0d bus released", tag, d), 64'(bus_idle(d)), 64'(1));
      check_rd(d, $sformatf("%s u%0d", tag, d));
    end
  endtask

  task automatic clear_model_regs();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) e_rd[d][p] = 32'h0;
      lastg[d] = NP - 1;
    end
  endtask

  initial begin
    logic [NP*32-1:0] rv;
    logic [NP-1:0] seen;
    bit idle_ok;

    rst_n = 1'b0;
    clear_req(0);
    clear_req(1);
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'h0; mem1[i] = 32'h0;
      ref_mem[0][i] = 32'h0; ref_mem[1][i] = 32'h0;
    end
    for (int d = 0; d < 2; d++) begin
      ref_mem[d][10'h123] = 32'hDEADBEEF;
      for (int p = 0; p < NP; p++) ref_mem[d][10'h300 + 10'(p)] = 32'hB000_0000 + 32'(p);
    end
    mem0[10'h123] = 32'hDEADBEEF;
    mem1[10'h123] = 32'hDEADBEEF;
    for (int p = 0; p < NP; p++) begin
      mem0[10'h300 + 10'(p)] = 32'hB000_0000 + 32'(p);
      mem1[10'h300 + 10'(p)] = 32'hB000_0000 + 32'(p);
    end
    clear_model_regs();

    tbl[0] = '{0, 0, 1'b1, 1'b0, 22'h000123, 32'h00000000, 4'hF, 32'hDEADBEEF};
    tbl[1] = '{0, 1, 1'b0, 1'b1, 22'h000040, 32'h11223344, 4'b0101, 32'h00000000};
    tbl[2] = '{0, 1, 1'b1, 1'b0, 22'h000040, 32'h00000000, 4'hF, 32'h00220044};
    tbl[3] = '{0, 2, 1'b0, 1'b1, 22'h000041, 32'hA5A5A5A5, 4'hF, 32'h00000000};
    tbl[4] = '{0, 2, 1'b1, 1'b0, 22'h000041, 32'h00000000, 4'hF, 32'hA5A5A5A5};
    tbl[5] = '{0, 0, 1'b0, 1'b1, 22'h000041, 32'hFFFF0000, 4'b1100, 32'hDEADBEEF};
    tbl[6] = '{0, 1, 1'b1, 1'b0, 22'h000041, 32'h00000000, 4'hF, 32'hFFFFA5A5};
    tbl[7] = '{0, 0, 1'b1, 1'b1, 22'h000050, 32'hCAFEF00D, 4'hF, 32'hDEADBEEF};
    tbl[8] = '{0, 2, 1'b1, 1'b0, 22'h000050, 32'h00000000, 4'hF, 32'hCAFEF00D};
    tbl[9] = '{1, 2, 1'b1, 1'b0, 22'h000123, 32'h00000000, 4'hF, 32'hDEADBEEF};

    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        if (strobes_of(d) !== 2'b11 || ack_of(d) !== '0 || !bus_idle(d)) idle_ok = 1'b0;
    end
    check("no request idle", 64'(idle_ok), 64'(1));

    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i].d, tbl[i].p, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].w, tbl[i].be,
           $sformatf("vec%0d", i));
      rv = rdata_of(tbl[i].d);
      check($sformatf("vec%0d table rddata", i), 64'(rv[tbl[i].p*32 +: 32]), 64'(tbl[i].exp));
    end

    contend(0, 0, 4, "fixed");
    contend(1, 1, 6, "rr");

    // Reset in the middle of a four-cycle write
    set_req(1, 1, 1'b0, 1'b1, 22'h000060, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid-write wr_n low", 64'(strobes_of(1)), 64'(2'b10));
    rst_n = 1'b0;
    #1;
    clear_req(1);
    clear_model_regs();
    reset_checks("mid-access reset");
    @(negedge clk);
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen = seen | ack1;
    end
    check("no ack after reset", 64'(seen), 64'(0));
    contend(1, 1, 3, "post-reset rr");

    rand_run(1, 1, 25);
    rand_run(0, 0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
